uart_tx_mmio: RTL

//  Memory-mapped UART transmitter on the CPU store path. It is downstream of the cpu core and

---
 rtl/uart_tx_mmio.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter snooping the CPU store bus.
// Stores to TXDATA queue a byte; STATUS is readable combinationally and
// its overflow flag is cleared by writing 1 to bit 3.
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        tx
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         fifo_mem [FIFO_DEPTH];

  logic        push_req, push_ok, pop, ovf_clr;
  logic        fifo_empty, fifo_full, baud_last;
  logic [7:0]  fifo_head;
  logic [31:0] status;

  // Only the low byte and the overflow-clear bit of a store are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^write_data[31:8];

  assign push_req   = write_enable && (write_address == BASE_ADDR);
  assign ovf_clr    = write_enable && (write_address == STATUS_ADDR) && write_data[3];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign baud_last  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx         = tx_q;

  // Serialiser FSM: next state, baud/bit counters, shift register, pop request.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Back-to-back frame: reload straight into START with no idle gap.
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so tx is glitch-free.
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping: a pop frees a slot in the same edge, so push-while-full-and-popping is accepted.
  always_comb begin
    push_ok    = push_req && (!fifo_full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // State register with asynchronous reset; reset aborts any frame and idles the line.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count/pointers define validity, so stale contents are never read.
    if (push_ok) fifo_mem[wr_ptr_q] <= write_data[7:0];
  end

  // Combinational STATUS read path and read-mux select.
  always_comb begin
    status      = '0;
    status[0]   = (state_q != S_IDLE);
    status[1]   = fifo_full;
    status[2]   = fifo_empty;
    status[3]   = overflow_q;
    status[7:4] = 4'(count_q);
    read_data   = (read_address == STATUS_ADDR) ? status : 32'h0;
    hit         = (read_address == BASE_ADDR) || (read_address == STATUS_ADDR);
  end

endmodule
